// File: rtl/sdp_ram_bytewr.sv
// sdp_ram_bytewr -- single-clock simple-dual-port RAM with byte-lane writes.
//
// Write port A (ena/wea/addra/dina) and read port B (enb/addrb) share clk.
// After reset or clr, a sequencer writes zero to every word, one word per
// cycle. While it runs, init_done is low and both user ports are ignored.
// Reads pass through a READ_LATENCY-deep pipeline (1 or 2 stages). Each read
// produces exactly one doutb_valid pulse, and doutb holds its value between
// beats. With BYPASS=1, a read and a write to the same address in the same
// cycle return the new bytes for the lanes being written.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr            synchronous re-zero request (also flushes in-flight reads)
//   ena/wea/addra/dina   write port, wea bit i covers byte lane i
//   enb/addrb      read request
//   doutb/doutb_valid    read data and its 1-cycle qualifier
//   init_done      array zeroed, ports live

// One byte lane of storage. The read is asynchronous; the top registers it.
module sdp_ram_bytewr_lane #(
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [BYTE_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  fwd,
    output logic [BYTE_WIDTH-1:0] rdata
);
    logic [BYTE_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // The mem read sees the pre-write contents, so forwarding only has to
    // substitute this cycle's write byte on a colliding lane.
    assign rdata = fwd ? wdata : mem[raddr];
endmodule

module sdp_ram_bytewr #(
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1,
    localparam int WE_WIDTH    = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  ena,
    input  logic [WE_WIDTH-1:0]   wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  doutb_valid,
    output logic                  init_done
);
    localparam int STAGES = READ_LATENCY;
    // The counter is one bit wider than an address, so it can reach DEPTH.
    // That gives one extra cycle after the last zero-write before READY.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_INIT:
                if (clr)
                    cnt_nxt = '0;
                else if (cnt == DEPTH_W) begin
                    state_nxt = S_READY;
                    cnt_nxt   = '0;
                end else
                    cnt_nxt = cnt + 1'b1;
            S_READY:
                if (clr) begin
                    state_nxt = S_INIT;
                    cnt_nxt   = '0;
                end
            default: state_nxt = S_INIT;
        endcase
    end

    logic ready, a_ok, b_ok, init_wr, user_wr, rd_fire, collide;

    assign ready   = (state == S_READY);
    assign a_ok    = ({1'b0, addra} < DEPTH_W);
    assign b_ok    = ({1'b0, addrb} < DEPTH_W);
    assign init_wr = !ready && (cnt < DEPTH_W);
    // clr wins over user traffic in the same cycle.
    assign user_wr = ready && !clr && ena && a_ok;
    assign rd_fire = ready && !clr && enb;
    assign collide = user_wr && rd_fire && (addra == addrb);

    logic [ADDR_WIDTH-1:0]                 waddr;
    logic [WE_WIDTH-1:0][BYTE_WIDTH-1:0]   wdata_l, rdata_l;
    logic [DATA_WIDTH-1:0]                 rd_word;

    assign waddr   = ready ? addra : cnt[ADDR_WIDTH-1:0];
    assign wdata_l = ready ? dina : '0;

    for (genvar i = 0; i < WE_WIDTH; i++) begin : g_lane
        sdp_ram_bytewr_lane #(
            .BYTE_WIDTH (BYTE_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lane (
            .clk   (clk),
            .we    (init_wr || (user_wr && wea[i])),
            .waddr (waddr),
            .wdata (wdata_l[i]),
            .raddr (addrb),
            .fwd   ((BYPASS != 0) && collide && wea[i]),
            .rdata (rdata_l[i])
        );
    end

    // Out-of-range reads still produce a beat; they return zero.
    assign rd_word = b_ok ? rdata_l : '0;

    logic [STAGES:1]       vld_q;
    logic [STAGES:0]       vld_pipe;
    logic [DATA_WIDTH-1:0] dpipe [1:STAGES];

    assign vld_pipe = {vld_q, rd_fire};

    // Data registers load only with a valid beat, so doutb holds between
    // beats. clr kills beats past stage 1; stage 1 is already gated by
    // rd_fire.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vld_q <= '0;
            for (int s = 1; s <= STAGES; s++) dpipe[s] <= '0;
        end else begin
            vld_q[1] <= vld_pipe[0];
            if (vld_pipe[0]) dpipe[1] <= rd_word;
            for (int s = 2; s <= STAGES; s++) begin
                vld_q[s] <= vld_pipe[s-1] && !clr;
                if (vld_pipe[s-1] && !clr) dpipe[s] <= dpipe[s-1];
            end
        end

    assign doutb       = dpipe[STAGES];
    assign doutb_valid = vld_pipe[STAGES];
    assign init_done   = ready;
endmodule

// File: doc/sdp_ram_bytewr.md
# sdp_ram_bytewr

Parametrised single-clock simple-dual-port RAM with per-byte write enables, a selectable read pipeline depth, optional same-address write-to-read forwarding, and a built-in zero-initialisation sequencer. It is the general-purpose buffer between producer and consumer datapaths. Write port A and read port B share one clock. Every read produces a qualified output beat via `doutb_valid`.

## Interface
- `DATA_WIDTH`, 32, word width in bits; must be a multiple of `BYTE_WIDTH`
- `BYTE_WIDTH`, 8, bits per write-enable lane
- `DEPTH`, 1024, number of words; need not be a power of two
- `ADDR_WIDTH`, 10, address bits; must satisfy 2^`ADDR_WIDTH` >= `DEPTH`
- `READ_LATENCY`, 1, read pipeline depth; legal values are 1 or 2
- `BYPASS`, 1, 1 = write-first forwarding on address collision, 0 = read-old-data
- `WE_WIDTH`, derived as `DATA_WIDTH`/`BYTE_WIDTH`; not overridable

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `clr` in 1: synchronous request to re-zero the array.
- `ena` in 1: write port enable.
- `wea` in `WE_WIDTH`: byte-lane write enables; bit i covers `dina[i*BYTE_WIDTH +: BYTE_WIDTH]`.
- `addra` in `ADDR_WIDTH`: write address.
- `dina` in `DATA_WIDTH`: write data.
- `enb` in 1: read request.
- `addrb` in `ADDR_WIDTH`: read address.
- `doutb` out `DATA_WIDTH`: read data.
- `doutb_valid` out 1: `doutb` holds the result of a read issued `READ_LATENCY` cycles earlier.
- `init_done` out 1: array is initialised and both ports are live.

## Operation
- FSM states:
  - INIT: sweeps an internal counter from 0 to `DEPTH`-1, writing zero to one word per cycle.
  - READY: normal operation.
- Transitions:
  - `rst` puts the FSM in INIT with the counter at 0.
  - INIT goes to READY on the cycle after the write to address `DEPTH`-1.
  - `clr` high in READY goes to INIT with the counter at 0.
  - `clr` high in INIT restarts the counter at 0.
- In INIT:
  - `ena` and `enb` are ignored.
  - No user write occurs.
  - `doutb_valid` stays 0.
- Write in READY: when `ena`=1 and `addra` < `DEPTH`, each byte lane with `wea[i]`=1 is updated from `dina`; other lanes keep their contents.
  - `ena`=1 with `wea`=0 is a no-op.
- Read in READY: `enb`=1 captures `ram[addrb]` into stage 1.
  - `READ_LATENCY`=2 adds one further output register.
  - `addrb` >= `DEPTH` returns all zeros, still with valid=1.
- Collision: `enb`=1 and `ena`=1 in the same cycle with `addrb`==`addra`.
  - `BYPASS`=1: returned word takes `dina` for lanes with `wea[i]`=1 and the old contents for all other lanes.
  - `BYPASS`=0: returned word is the old contents.
- `doutb` holds its last value whenever no new valid beat arrives. `doutb_valid` is a 1-cycle pulse per read.
- `clr` flushes the read pipeline: any in-flight beat is dropped and its valid is never asserted.
- Back-to-back reads on consecutive cycles are fully pipelined, giving one beat per cycle.

## Timing
- Reset values:
  - `doutb`=0, `doutb_valid`=0, `init_done`=0.
  - FSM is in INIT with the counter at 0.
  - All read pipeline registers are 0.
- Initialisation:
  - The first zero-write occurs on the first rising edge after `rst` deasserts.
  - `init_done` rises exactly `DEPTH` cycles after that edge; the default `DEPTH` gives 1024 cycles.
- `rst` asserted mid-INIT or mid-READY clears immediately, without waiting for a clock, and the sweep restarts from 0.
- `init_done` falls on the edge that samples `clr`=1.
- Read latency: with `enb` sampled at edge N, data and valid appear after edge N+`READ_LATENCY`.
- A write sampled at edge N is visible to a non-colliding read sampled at edge N+1.

## Test plan
1. Reset and init, default params:
   - Release `rst`; `init_done` rises exactly 1024 cycles later.
   - Reads of addresses 0, 511 and 1023 each return 0x00000000 with valid=1.
2. Byte-lane write:
   - Write 0xAABBCCDD to address 5 with `wea`=4'b1111, then 0x11223344 with `wea`=4'b0101.
   - Read of address 5 returns 0xAA22CC44.
3. Collision:
   - Address 7 holds 0x01020304; in one cycle write 0xFFFFFFFF with `wea`=4'b1000 and read address 7.
   - `BYPASS`=1 returns 0xFF020304.
   - `BYPASS`=0 returns 0x01020304.
4. Latency and throughput:
   - With `READ_LATENCY`=2, issue reads of addresses 0..3 on four consecutive cycles.
   - Valid is high on four consecutive cycles starting 2 cycles after the first request, returning the data in order.
5. Clear and reset mid-operation:
   - Assert `clr` with one read in flight: no valid pulse follows, `init_done` drops, and all previously written words read 0 after re-init.
   - Pulse `rst` at counter value 300: re-init takes a full 1024 cycles.
6. Non-power-of-two `DEPTH`=1000:
   - A write to address 1010 leaves every in-range word unchanged.
   - A read of address 1010 returns 0 with valid=1.
